// File: rtl/switch_input_conditioner_if.sv
// Signal bundle between the raw driver switches and the conditioner.
// Raw levels flow in; debounced levels and edge pulses flow out.
interface switch_input_conditioner_if;
    logic ignition_raw;
    logic hidden_sw_raw;
    logic break_raw;
    logic ignition_db;
    logic hidden_sw_db;
    logic break_db;
    logic ignition_rise;
    logic ignition_fall;
    logic hidden_sw_rise;
    logic break_rise;

    // Switch side: drives raw levels, observes conditioned results
    modport master (
        output ignition_raw,
        output hidden_sw_raw,
        output break_raw,
        input  ignition_db,
        input  hidden_sw_db,
        input  break_db,
        input  ignition_rise,
        input  ignition_fall,
        input  hidden_sw_rise,
        input  break_rise
    );

    // Conditioner side
    modport slave (
        input  ignition_raw,
        input  hidden_sw_raw,
        input  break_raw,
        output ignition_db,
        output hidden_sw_db,
        output break_db,
        output ignition_rise,
        output ignition_fall,
        output hidden_sw_rise,
        output break_rise
    );
endinterface

// File: rtl/switch_input_conditioner.sv
// Synchronizes and debounces the ignition, hidden-switch and brake inputs,
// producing flop-driven levels and one-cycle edge pulses in the clock domain.
module switch_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    switch_input_conditioner_if.slave sw
);
    localparam int NCH = 3;
    localparam int IGN = 0;
    localparam int HID = 1;
    localparam int BRK = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } db_state_e;

    // A one-cycle debounce window would let single-cycle glitches through
    if (DEBOUNCE_CYCLES < 2) begin : g_cfg_err
        $error("switch_input_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [NCH-1:0]   raw_s;
    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;
    logic [NCH-1:0]   level_s;
    logic [NCH-1:0]   flip_s;
    logic [NCH-1:0]   rise_d;
    logic [NCH-1:0]   rise_q;
    logic             ign_fall_d;
    logic             ign_fall_q;
    db_state_e        state_d [NCH];
    db_state_e        state_q [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];

    assign raw_s = {sw.break_raw, sw.hidden_sw_raw, sw.ignition_raw};

    // Two-flop synchronizer per channel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count consecutive disagreeing cycles, flip on the last one
    always_comb begin
        level_s    = 3'b000;
        flip_s     = 3'b000;
        rise_d     = 3'b000;
        ign_fall_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_s[i] = (state_q[i] == STABLE_HI);
            if (sync2_q[i] == level_s[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
                flip_s[i] = 1'b1;
                cnt_d[i]  = CNT_ZERO;
                case (state_q[i])
                    STABLE_LO: state_d[i] = STABLE_HI;
                    STABLE_HI: state_d[i] = STABLE_LO;
                    default:   state_d[i] = STABLE_LO;
                endcase
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        rise_d     = flip_s & ~level_s;
        ign_fall_d = flip_s[IGN] & level_s[IGN];
    end

    // Stable level and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= STABLE_LO;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Edge pulses land in the same edge as the level flip
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rise_q     <= 3'b000;
            ign_fall_q <= 1'b0;
        end else begin
            rise_q     <= rise_d;
            ign_fall_q <= ign_fall_d;
        end
    end

    assign sw.ignition_db    = (state_q[IGN] == STABLE_HI);
    assign sw.hidden_sw_db   = (state_q[HID] == STABLE_HI);
    assign sw.break_db       = (state_q[BRK] == STABLE_HI);
    assign sw.ignition_rise  = rise_q[IGN];
    assign sw.ignition_fall  = ign_fall_q;
    assign sw.hidden_sw_rise = rise_q[HID];
    assign sw.break_rise     = rise_q[BRK];
endmodule

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench: a raw-level streak model predicts every output each cycle.
module tb_switch_input_conditioner;
    localparam int D = 4;

    logic clock;
    logic reset;
    int   check_cnt;
    int   pass_cnt;

    switch_input_conditioner_if sw_if ();

    switch_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock (clock),
        .reset (reset),
        .sw    (sw_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: two-stage delay, debounced level, disagreement streak
    logic [2:0] m_s1, m_s2, m_db, m_rise;
    logic       m_fall;
    int         m_streak [3];
    logic [6:0] sb_q [$];

    function automatic logic [6:0] observed();
        return {sw_if.break_db, sw_if.hidden_sw_db, sw_if.ignition_db,
                sw_if.break_rise, sw_if.hidden_sw_rise, sw_if.ignition_rise,
                sw_if.ignition_fall};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic model_reset();
        m_s1 = 3'b000; m_s2 = 3'b000; m_db = 3'b000; m_rise = 3'b000; m_fall = 1'b0;
        for (int i = 0; i < 3; i++) m_streak[i] = 0;
        sb_q.delete();
    endtask

    task automatic model_edge(input logic [2:0] raw);
        m_rise = 3'b000;
        m_fall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] !== m_db[i]) begin
                m_streak[i]++;
                if (m_streak[i] == D) begin
                    m_db[i]     = m_s2[i];
                    m_streak[i] = 0;
                    if (m_s2[i]) m_rise[i] = 1'b1;
                    else if (i == 0) m_fall = 1'b1;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        sb_q.push_back({m_db, m_rise, m_fall});
    endtask

    // Entered at a falling edge; drives raw, steps model, checks after the rising edge
    task automatic cyc(input logic [2:0] raw, input string tag, output logic [6:0] seen);
        logic [6:0] exp;
        sw_if.ignition_raw  = raw[0];
        sw_if.hidden_sw_raw = raw[1];
        sw_if.break_raw     = raw[2];
        model_edge(raw);
        @(posedge clock);
        #1;
        seen = observed();
        exp  = sb_q.pop_front();
        check_val(tag, {25'd0, seen}, {25'd0, exp});
        @(negedge clock);
    endtask

    initial begin
        logic [6:0] seen;
        logic [2:0] raw;
        int first, pulses, both;
        check_cnt = 0;
        pass_cnt  = 0;
        reset = 1'b1;
        sw_if.ignition_raw = 1'b0; sw_if.hidden_sw_raw = 1'b0; sw_if.break_raw = 1'b0;
        model_reset();
        #12;
        check_val("reset_state", {25'd0, observed()}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1: ignition rises on edge 6 with a single rise pulse
        first = 0; pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            cyc(3'b001, "t1_ign_rise", seen);
            if (seen[4] && first == 0) first = e;
            if (seen[1]) pulses++;
        end
        check_val("t1_latency", first, 6);
        check_val("t1_pulses", pulses, 1);

        // 2: three-cycle hidden switch glitch is rejected
        pulses = 0;
        for (int e = 0; e < 9; e++) begin
            cyc((e < 3) ? 3'b011 : 3'b001, "t2_hid_glitch", seen);
            if (seen[5] || seen[2]) pulses++;
        end
        check_val("t2_no_hid", pulses, 0);

        // 3: brake bounce then hold
        pulses = 0; first = 0;
        for (int e = 0; e < 14; e++) begin
            raw = (e < 5) ? ((e % 2 == 0) ? 3'b101 : 3'b001) : 3'b101;
            cyc(raw, "t3_brk_bounce", seen);
            if (seen[3]) pulses++;
            if (seen[6] && first == 0) first = e + 1;
        end
        check_val("t3_brk_pulses", pulses, 1);
        check_val("t3_brk_latency", first, 10);

        // 4: ignition falls with a fall pulse and no rise
        first = 0; pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            cyc(3'b100, "t4_ign_fall", seen);
            if (!seen[4] && first == 0) first = e;
            if (seen[1]) pulses++;
        end
        check_val("t4_latency", first, 6);
        check_val("t4_no_rise", pulses, 0);

        // 5: reset mid-count, then full latency from release
        for (int e = 0; e < 4; e++) cyc(3'b101, "t5_precount", seen);
        reset = 1'b1;
        #1;
        check_val("t5_async_clr", {25'd0, observed()}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        first = 0;
        for (int e = 1; e <= 8; e++) begin
            cyc(3'b101, "t5_after_rst", seen);
            if (seen[4] && first == 0) first = e;
        end
        check_val("t5_latency", first, 6);

        // 6: all channels rise together
        for (int e = 0; e < 8; e++) cyc(3'b000, "t6_clear", seen);
        both = 0; first = 0;
        for (int e = 1; e <= 8; e++) begin
            cyc(3'b111, "t6_all_rise", seen);
            if (seen[3:1] == 3'b111) begin both++; first = e; end
        end
        check_val("t6_joint_pulse", both, 1);
        check_val("t6_joint_edge", first, 6);

        // Random bouncing on all channels
        raw = 3'b111;
        for (int e = 0; e < 80; e++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(3, 0) == 0) raw[i] = ~raw[i];
            cyc(raw, "rand_bounce", seen);
        end

        // Asynchronous clear with all levels high
        for (int e = 0; e < 8; e++) cyc(3'b111, "final_hold", seen);
        check_val("final_all_hi", {29'd0, seen[6:4]}, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check_val("final_async_clr", {25'd0, observed()}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
